// File: rtl/addsub_pkg.sv
// addsub_pkg: shared FSM state and ctrl encodings for digit_serial_addsub
package addsub_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
endpackage

// File: rtl/digit_serial_addsub_fa.sv
// full_adder_cell: one-bit full adder, the building block of the per-cycle ripple stage
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: multi-cycle two's-complement add/sub, DIGIT bits per clock
module digit_serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t           state, state_nx;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] sa, sb, acc, acc_nx;
  logic [DIGIT-1:0] ds;
  logic [DIGIT:0]   c;
  logic             last;

  assign c[0] = carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder_cell u_fa (
      .a   (sa[i]),
      .b   (sb[i]),
      .cin (c[i]),
      .sum (ds[i]),
      .cout(c[i+1])
    );
  end

  // the new digit enters at the top so after NDIG shifts the accumulator is in place
  assign acc_nx = (acc >> DIGIT) | (WIDTH'(ds) << (WIDTH - DIGIT));
  assign last   = (state == RUN) && (idx == IW'(NDIG - 1));
  assign busy   = (state == RUN);

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  // next state: start only honoured while idle, leave RUN after the last digit
  always_comb begin
    state_nx = (state == IDLE) ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  end

  // operand capture, digit processing and result commit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      sa    <= '0;
      sb    <= '0;
      acc   <= '0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      done <= last;
      if (state == IDLE) begin
        if (start) begin
          sa    <= a;
          sb    <= b ^ {WIDTH{ctrl}};
          carry <= (ctrl == SUB);
          idx   <= '0;
        end
      end else begin
        sa    <= sa >> DIGIT;
        sb    <= sb >> DIGIT;
        acc   <= acc_nx;
        carry <= c[DIGIT];
        idx   <= idx + IW'(1);
        if (last) begin
          sum  <= acc_nx;
          cout <= c[DIGIT];
          ovf  <= c[DIGIT] ^ c[DIGIT-1];
          zero <= (acc_nx == '0);
        end
      end
    end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// tb_digit_serial_addsub: directed and random checks of digit_serial_addsub against an arithmetic model
module tb_digit_serial_addsub;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, ctrl = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, cout, ovf, zero;
  logic [15:0] sum;
  logic        ss = 1'b0, cs = 1'b0;
  logic [15:0] as = '0, bs = '0;
  logic [2:0]  bsy_s, dn_s, co_s, ov_s, z_s;
  logic [2:0][15:0] sm_s;
  int          tests = 0, fails = 0;
  logic [15:0] held = '0;

  always #5 clk = ~clk;

  digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ctrl(ctrl),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(ss), .a(as), .b(bs), .ctrl(cs),
    .busy(bsy_s[0]), .done(dn_s[0]), .sum(sm_s[0]), .cout(co_s[0]), .ovf(ov_s[0]), .zero(z_s[0]));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .start(ss), .a(as), .b(bs), .ctrl(cs),
    .busy(bsy_s[1]), .done(dn_s[1]), .sum(sm_s[1]), .cout(co_s[1]), .ovf(ov_s[1]), .zero(z_s[1]));

  digit_serial_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(ss), .a(as), .b(bs), .ctrl(cs),
    .busy(bsy_s[2]), .done(dn_s[2]), .sum(sm_s[2]), .cout(co_s[2]), .ovf(ov_s[2]), .zero(z_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {cout, ovf, zero, sum} from plain integer arithmetic
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    int r;
    logic [15:0] s;
    logic co, ov;
    r  = c ? int'($signed(x)) - int'($signed(y)) : int'($signed(x)) + int'($signed(y));
    s  = c ? x - y : x + y;
    co = c ? (x >= y) : (int'(x) + int'(y) > 65535);
    ov = (r > 32767) || (r < -32768);
    return {co, ov, s == 16'h0, s};
  endfunction

  // launch one op on the DIGIT=4 instance; returns at the sample where done is high
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                       input bit poke, input string tag);
    logic [18:0] e;
    int lat, nb, hb;
    e = model(x, y, c);
    a = x; b = y; ctrl = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " accept"}, 32'({busy, done}), 32'h2);
    lat = 0; nb = 0; hb = 0;
    while (!done && lat < 40) begin
      if (busy) nb++;
      if (sum !== held) hb++;
      if (lat == 1) begin
        a = 16'($urandom); b = 16'($urandom); ctrl = ~c;
        if (poke) start = 1'b1;
      end
      if (lat == 2) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " busy cycles"}, nb, 4);
    chk({tag, " held"}, hb, 0);
    chk({tag, " busy at done"}, 32'(busy), 32'h0);
    chk({tag, " result"}, 32'({cout, ovf, zero, sum}), 32'(e));
    held = e[15:0];
  endtask

  initial begin
    int dn;
    int lat [3];
    int exl [3];
    logic [15:0] x, y;
    @(negedge clk);
    chk("reset outputs", 32'({busy, done, cout, ovf, zero, sum}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, "add");
    chk("add const", 32'({cout, ovf, zero, sum}), 32'h02233);
    @(negedge clk);
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0, "sub borrow");
    chk("sub const", 32'({cout, ovf, zero, sum}), 32'h0FFFE);
    @(negedge clk);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "add ovf");
    chk("add ovf const", 32'({cout, ovf, zero, sum}), 32'h28000);
    @(negedge clk);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, "sub ovf");
    chk("sub ovf const", 32'({cout, ovf, zero, sum}), 32'h67FFF);
    @(negedge clk);
    do_op(16'h1234, 16'h1234, 1'b1, 1'b0, "sub zero");
    chk("zero const", 32'({cout, ovf, zero, sum}), 32'h50000);
    @(negedge clk);
    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b1, "ignored start");
    do_op(16'hABCD, 16'h1111, 1'b1, 1'b0, "back to back");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "back to back 2");
    @(negedge clk);

    a = 16'h4321; b = 16'h1111; ctrl = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset", 32'({busy, done, cout, ovf, zero, sum}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    held = '0;
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no done after abort", dn, 0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "after reset");
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      x = ($urandom_range(0, 3) == 0) ? 16'h7FFF << $urandom_range(0, 1) : 16'($urandom);
      y = ($urandom_range(0, 3) == 0) ? 16'hFFFF >> $urandom_range(0, 15) : 16'($urandom);
      do_op(x, y, 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    exl = '{16, 2, 1};
    lat = '{-1, -1, -1};
    as = 16'h1234; bs = 16'h0FFF; cs = 1'b0; ss = 1'b1;
    @(negedge clk);
    ss = 1'b0;
    for (int n = 0; n < 40 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); n++) begin
      for (int k = 0; k < 3; k++) if (dn_s[k] && lat[k] < 0) lat[k] = n;
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sweep%0d latency", k), lat[k], exl[k]);
      chk($sformatf("sweep%0d result", k),
          32'({bsy_s[k], co_s[k], ov_s[k], z_s[k], sm_s[k]}), 32'h02233);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
